// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg
//   Shared definitions for the RFC1662-style framer/deframer pair:
//   framing byte values, FCS-16 (CRC-16/X-25) constants, completion status
//   codes, receiver state encoding and a one-byte FCS update function.
package uart_frame_pkg;

   localparam logic [7:0]  FLAG     = 8'h7E;
   localparam logic [7:0]  ESC      = 8'h7D;
   localparam logic [7:0]  ESC_XOR  = 8'h20;
   localparam logic [15:0] FCS_INIT = 16'hFFFF;
   localparam logic [15:0] FCS_GOOD = 16'hF0B8;  // residue after a frame plus its own FCS
   localparam logic [15:0] FCS_POLY = 16'h8408;  // 0x1021 bit-reversed

   localparam logic [1:0] ERR_OK    = 2'd0;
   localparam logic [1:0] ERR_FCS   = 2'd1;
   localparam logic [1:0] ERR_LEN   = 2'd2;
   localparam logic [1:0] ERR_ABORT = 2'd3;

   typedef enum logic [1:0] {
      ST_HUNT = 2'd0,
      ST_FLAG = 2'd1,
      ST_DATA = 2'd2,
      ST_ESC  = 2'd3
   } rx_state_t;

   // Fold one byte into the running FCS, LSB first.
   function automatic logic [15:0] fcs16_byte(input logic [15:0] fcs_in, input logic [7:0] byte_in);
      logic [15:0] c;
      c = fcs_in ^ {8'h00, byte_in};
      for (int i = 0; i < 8; i++) begin
         if (c[0]) begin
            c = {1'b0, c[15:1]} ^ FCS_POLY;
         end else begin
            c = {1'b0, c[15:1]};
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/uart_frame_rx_fcs16_accum.sv
// fcs16_accum
//   Running FCS-16 register. Shared between the receive deframer and the
//   transmit framer.
//   clk, reset : clock, async active-high reset (register -> FCS_INIT)
//   clear      : synchronous return to FCS_INIT (wins over update)
//   update     : fold data[7:0] into the register this cycle
//   fcs[15:0]  : current register value
module fcs16_accum
   import uart_frame_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        update,
   input  logic [7:0]  data,
   output logic [15:0] fcs
);

   logic [15:0] fcs_q;

   // FCS register with clear priority over update
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fcs_q <= FCS_INIT;
      end else if (clear) begin
         fcs_q <= FCS_INIT;
      end else if (update) begin
         fcs_q <= fcs16_byte(fcs_q, data);
      end else begin
         fcs_q <= fcs_q;
      end
   end

   assign fcs = fcs_q;

endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx
//   Deframes a uart_rx byte stream: 0x7E flags, 0x7D escapes, FCS-16 check.
//   Payload streams out unbuffered with the two FCS bytes held back by a
//   2-entry delay line; a status pulse follows each frame.
//   clk, reset             : clock, async active-high reset
//   in_data/in_strobe      : incoming byte and its one-cycle valid
//   out_data/out_strobe    : de-escaped payload byte and its valid
//   frame_done             : end-of-frame pulse (close, abort, overflow)
//   frame_err/frame_len    : status and OK length, held until next frame_done
module uart_frame_rx
   import uart_frame_pkg::*;
#(
   parameter int MAX_LEN = 256,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       in_data,
   input  logic             in_strobe,
   output logic [7:0]       out_data,
   output logic             out_strobe,
   output logic             frame_done,
   output logic [1:0]       frame_err,
   output logic [LEN_W-1:0] frame_len
);

   localparam int CNT_W = $clog2(MAX_LEN + 4);
   // Count just before the byte that would overflow the frame
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LEN + 2);

   rx_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       dly0_q, dly0_d, dly1_q, dly1_d;  // dly0 is the older byte
   logic [7:0]       out_data_q, out_data_d;
   logic             out_strobe_q, out_strobe_d;
   logic             frame_done_q, frame_done_d;
   logic [1:0]       frame_err_q, frame_err_d;
   logic [LEN_W-1:0] frame_len_q, frame_len_d;

   logic             accept_s, close_s, abort_s, ovf_s;
   logic [7:0]       acc_byte_s;
   logic             fcs_clear_s, fcs_update_s;
   logic [15:0]      fcs_s;

   fcs16_accum u_fcs (
      .clk    (clk),
      .reset  (reset),
      .clear  (fcs_clear_s),
      .update (fcs_update_s),
      .data   (acc_byte_s),
      .fcs    (fcs_s)
   );

   // Classify the incoming byte against the current state
   always_comb begin
      accept_s   = 1'b0;
      close_s    = 1'b0;
      abort_s    = 1'b0;
      acc_byte_s = in_data;
      if (in_strobe) begin
         case (state_q)
            ST_FLAG: begin
               if ((in_data != FLAG) && (in_data != ESC)) begin
                  accept_s = 1'b1;
               end else begin
                  accept_s = 1'b0;
               end
            end
            ST_DATA: begin
               if (in_data == FLAG) begin
                  close_s = 1'b1;
               end else if (in_data != ESC) begin
                  accept_s = 1'b1;
               end else begin
                  accept_s = 1'b0;
               end
            end
            ST_ESC: begin
               if (in_data == FLAG) begin
                  abort_s = 1'b1;
               end else begin
                  accept_s   = 1'b1;
                  acc_byte_s = in_data ^ ESC_XOR;
               end
            end
            default: begin
               accept_s = 1'b0;
            end
         endcase
      end else begin
         accept_s = 1'b0;
      end
      ovf_s = accept_s && (cnt_q == CNT_LAST);
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (ovf_s) begin
         state_d = ST_HUNT;
      end else if (in_strobe) begin
         case (state_q)
            ST_HUNT: state_d = (in_data == FLAG) ? ST_FLAG : ST_HUNT;
            ST_FLAG: begin
               if (in_data == FLAG) begin
                  state_d = ST_FLAG;
               end else if (in_data == ESC) begin
                  state_d = ST_ESC;
               end else begin
                  state_d = ST_DATA;
               end
            end
            ST_DATA: begin
               if (in_data == FLAG) begin
                  state_d = ST_FLAG;
               end else if (in_data == ESC) begin
                  state_d = ST_ESC;
               end else begin
                  state_d = ST_DATA;
               end
            end
            ST_ESC:  state_d = (in_data == FLAG) ? ST_FLAG : ST_DATA;
            default: state_d = ST_HUNT;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Output / datapath next-state: counter, delay line, payload and status
   always_comb begin
      cnt_d        = cnt_q;
      dly0_d       = dly0_q;
      dly1_d       = dly1_q;
      out_data_d   = out_data_q;
      out_strobe_d = 1'b0;
      frame_done_d = 1'b0;
      frame_err_d  = frame_err_q;
      frame_len_d  = frame_len_q;
      fcs_clear_s  = 1'b0;
      fcs_update_s = 1'b0;
      if (ovf_s) begin
         frame_done_d = 1'b1;
         frame_err_d  = ERR_LEN;
         frame_len_d  = '0;
         cnt_d        = '0;
         fcs_clear_s  = 1'b1;
      end else if (accept_s) begin
         fcs_update_s = 1'b1;
         cnt_d        = cnt_q + CNT_W'(1);
         // The line always shifts; it only holds two real bytes once cnt >= 2
         dly0_d       = dly1_q;
         dly1_d       = acc_byte_s;
         if (cnt_q >= CNT_W'(2)) begin
            out_strobe_d = 1'b1;
            out_data_d   = dly0_q;
         end else begin
            out_strobe_d = 1'b0;
         end
      end else if (close_s) begin
         frame_done_d = 1'b1;
         cnt_d        = '0;
         fcs_clear_s  = 1'b1;
         if (cnt_q < CNT_W'(3)) begin
            frame_err_d = ERR_LEN;
            frame_len_d = '0;
         end else if (fcs_s != FCS_GOOD) begin
            frame_err_d = ERR_FCS;
            frame_len_d = '0;
         end else begin
            frame_err_d = ERR_OK;
            frame_len_d = LEN_W'(cnt_q - CNT_W'(2));
         end
      end else if (abort_s) begin
         frame_done_d = 1'b1;
         frame_err_d  = ERR_ABORT;
         frame_len_d  = '0;
         cnt_d        = '0;
         fcs_clear_s  = 1'b1;
      end else begin
         fcs_clear_s  = 1'b0;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q        <= '0;
         dly0_q       <= 8'h00;
         dly1_q       <= 8'h00;
         out_data_q   <= 8'h00;
         out_strobe_q <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= ERR_OK;
         frame_len_q  <= '0;
      end else begin
         cnt_q        <= cnt_d;
         dly0_q       <= dly0_d;
         dly1_q       <= dly1_d;
         out_data_q   <= out_data_d;
         out_strobe_q <= out_strobe_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
         frame_len_q  <= frame_len_d;
      end
   end

   assign out_data   = out_data_q;
   assign out_strobe = out_strobe_q;
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;
   assign frame_len  = frame_len_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx
//   Directed self-checking bench for uart_frame_rx. A default-size instance
//   covers normal framing; a MAX_LEN=4 instance covers overflow.
module tb_uart_frame_rx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_strobe = 1'b0;
   logic       sel_small = 1'b0;
   logic       strobe_a, strobe_b;

   logic [7:0] out_data_a, out_data_b;
   logic       out_strobe_a, out_strobe_b;
   logic       frame_done_a, frame_done_b;
   logic [1:0] frame_err_a, frame_err_b;
   logic [8:0] frame_len_a;
   logic [2:0] frame_len_b;

   int checks = 0;
   int errors = 0;

   logic [7:0] rx_a[$];
   logic [7:0] rx_b[$];
   int         done_a = 0;
   int         done_b = 0;

   logic [7:0] tx_q[$];
   logic [7:0] pl_q[$];

   assign strobe_a = in_strobe & ~sel_small;
   assign strobe_b = in_strobe &  sel_small;

   always #5 clk = ~clk;

   uart_frame_rx dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_strobe(strobe_a),
      .out_data(out_data_a), .out_strobe(out_strobe_a), .frame_done(frame_done_a),
      .frame_err(frame_err_a), .frame_len(frame_len_a)
   );

   uart_frame_rx #(.MAX_LEN(4)) dut_small (
      .clk(clk), .reset(reset), .in_data(in_data), .in_strobe(strobe_b),
      .out_data(out_data_b), .out_strobe(out_strobe_b), .frame_done(frame_done_b),
      .frame_err(frame_err_b), .frame_len(frame_len_b)
   );

   // Capture outputs on the inactive edge
   always @(negedge clk) begin
      if (out_strobe_a) rx_a.push_back(out_data_a);
      if (frame_done_a) done_a++;
      if (out_strobe_b) rx_b.push_back(out_data_b);
      if (frame_done_b) done_b++;
      if (out_strobe_a || frame_done_a) begin
         checks++;
         if (out_strobe_a && frame_done_a) begin
            errors++;
            $display("FAIL excl_a: out_strobe=%0b frame_done=%0b, required not both", out_strobe_a, frame_done_a);
         end
      end
   end

   // Independent bit-serial CRC-16/X-25 model
   function automatic logic [15:0] model_fcs();
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      foreach (pl_q[k]) begin
         for (int j = 0; j < 8; j++) begin
            fb = c[0] ^ pl_q[k][j];
            c  = c >> 1;
            if (fb) c = c ^ 16'h8408;
         end
      end
      return ~c;
   endfunction

   task automatic push_esc(input logic [7:0] b);
      if (b == 8'h7E || b == 8'h7D) begin
         tx_q.push_back(8'h7D);
         tx_q.push_back(b ^ 8'h20);
      end else begin
         tx_q.push_back(b);
      end
   endtask

   // Frame pl_q into tx_q with opening/closing flags and model FCS
   task automatic build_frame();
      logic [15:0] f;
      f = model_fcs();
      tx_q = {8'h7E};
      foreach (pl_q[k]) push_esc(pl_q[k]);
      push_esc(f[7:0]);
      push_esc(f[15:8]);
      tx_q.push_back(8'h7E);
   endtask

   task automatic send_seq(input bit b2b);
      foreach (tx_q[k]) begin
         @(negedge clk);
         in_data   = tx_q[k];
         in_strobe = 1'b1;
         if (!b2b) begin
            @(negedge clk);
            in_strobe = 1'b0;
         end
      end
      if (b2b) begin
         @(negedge clk);
         in_strobe = 1'b0;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic clear_capture();
      rx_a.delete();
      rx_b.delete();
      done_a = 0;
      done_b = 0;
   endtask

   task automatic check_status_a(input string name, input int exp_done, input logic [1:0] exp_err,
                                 input logic [8:0] exp_len);
      checks++;
      if (done_a !== exp_done) begin
         errors++;
         $display("FAIL %s_done: got %0d frame_done, required %0d", name, done_a, exp_done);
      end
      if (exp_done > 0) begin
         checks++;
         if (frame_err_a !== exp_err || frame_len_a !== exp_len) begin
            errors++;
            $display("FAIL %s_status: err=%0d len=%0d, required err=%0d len=%0d",
                     name, frame_err_a, frame_len_a, exp_err, exp_len);
         end
      end
   endtask

   task automatic check_payload_a(input string name);
      checks++;
      if (rx_a.size() !== pl_q.size()) begin
         errors++;
         $display("FAIL %s_count: got %0d out_strobe, required %0d", name, rx_a.size(), pl_q.size());
      end else begin
         foreach (pl_q[k]) begin
            checks++;
            if (rx_a[k] !== pl_q[k]) begin
               errors++;
               $display("FAIL %s_byte%0d: got %02h, required %02h", name, k, rx_a[k], pl_q[k]);
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({out_data_a, out_strobe_a, frame_done_a, frame_err_a, frame_len_a} !== 21'd0) begin
         errors++;
         $display("FAIL reset_outputs: data=%02h strb=%0b done=%0b err=%0d len=%0d, required all 0",
                  out_data_a, out_strobe_a, frame_done_a, frame_err_a, frame_len_a);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_good_frame(input bit b2b);
      clear_capture();
      pl_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      tx_q = {8'h7E, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h6E, 8'h90, 8'h7E};
      send_seq(b2b);
      check_payload_a(b2b ? "b2b" : "good");
      check_status_a(b2b ? "b2b" : "good", 1, 2'd0, 9'd9);
   endtask

   task automatic test_bad_fcs();
      clear_capture();
      pl_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      tx_q = {8'h7E, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h6E, 8'h91, 8'h7E};
      send_seq(1'b0);
      check_payload_a("badfcs");
      check_status_a("badfcs", 1, 2'd1, 9'd0);
   endtask

   task automatic test_escapes();
      clear_capture();
      pl_q = {8'h7E, 8'h7D, 8'h11};
      build_frame();
      send_seq(1'b0);
      check_payload_a("esc");
      check_status_a("esc", 1, 2'd0, 9'd3);
   endtask

   task automatic test_abort_flags_short();
      clear_capture();
      pl_q.delete();
      tx_q = {8'h7E, 8'h41, 8'h42, 8'h7D, 8'h7E};
      send_seq(1'b0);
      check_payload_a("abort");
      check_status_a("abort", 1, 2'd3, 9'd0);
      clear_capture();
      tx_q = {8'h7E, 8'h7E, 8'h7E};
      send_seq(1'b0);
      check_status_a("flags", 0, 2'd0, 9'd0);
      clear_capture();
      tx_q = {8'h7E, 8'h41, 8'h7E};
      send_seq(1'b0);
      check_payload_a("short");
      check_status_a("short", 1, 2'd2, 9'd0);
   endtask

   task automatic test_reset_midframe();
      tx_q = {8'h7E, 8'h31, 8'h32, 8'h33, 8'h34};
      send_seq(1'b0);
      clear_capture();
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({out_data_a, out_strobe_a, frame_done_a, frame_err_a, frame_len_a} !== 21'd0) begin
         errors++;
         $display("FAIL midreset_outputs: data=%02h strb=%0b done=%0b err=%0d len=%0d, required all 0",
                  out_data_a, out_strobe_a, frame_done_a, frame_err_a, frame_len_a);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      // Same good frame but missing its opening flag: must be hunted past
      pl_q.delete();
      tx_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h6E, 8'h90, 8'h7E};
      send_seq(1'b0);
      check_payload_a("noflag");
      check_status_a("midreset", 0, 2'd0, 9'd0);
   endtask

   task automatic test_overflow();
      sel_small = 1'b1;
      clear_capture();
      tx_q = {8'h7E, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
      send_seq(1'b0);
      checks++;
      if (rx_b.size() !== 4 || done_b !== 1 || frame_err_b !== 2'd2 || frame_len_b !== 3'd0) begin
         errors++;
         $display("FAIL ovf: strobes=%0d done=%0d err=%0d len=%0d, required 4 1 2 0",
                  rx_b.size(), done_b, frame_err_b, frame_len_b);
      end else begin
         checks++;
         if ({rx_b[0], rx_b[1], rx_b[2], rx_b[3]} !== 32'h01020304) begin
            errors++;
            $display("FAIL ovf_bytes: got %02h %02h %02h %02h, required 01 02 03 04",
                     rx_b[0], rx_b[1], rx_b[2], rx_b[3]);
         end
      end
      clear_capture();
      pl_q = {8'hA1, 8'h7E, 8'hA3, 8'hA4};
      build_frame();
      send_seq(1'b0);
      checks++;
      if (rx_b.size() !== 4 || done_b !== 1 || frame_err_b !== 2'd0 || frame_len_b !== 3'd4) begin
         errors++;
         $display("FAIL ovf_next: strobes=%0d done=%0d err=%0d len=%0d, required 4 1 0 4",
                  rx_b.size(), done_b, frame_err_b, frame_len_b);
      end else begin
         checks++;
         if ({rx_b[0], rx_b[1], rx_b[2], rx_b[3]} !== 32'hA17EA3A4) begin
            errors++;
            $display("FAIL ovf_next_bytes: got %02h %02h %02h %02h, required a1 7e a3 a4",
                     rx_b[0], rx_b[1], rx_b[2], rx_b[3]);
         end
      end
      sel_small = 1'b0;
   endtask

   initial begin
      test_reset();
      test_good_frame(1'b0);
      test_bad_fcs();
      test_escapes();
      test_abort_flags_short();
      test_reset_midframe();
      tx_q = {8'h7E};
      send_seq(1'b0);
      test_good_frame(1'b1);
      test_overflow();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
